rsa_exp_ctrl: RTL
=================

# rsa_exp_ctrl

Sequencer for the RSA modular-exponentiation datapath: runs Montgomery left-to-right square-and-multiply over a fixed-width exponent. Each step drives the two operand-select muxes (select codes 00 = constant one, 01 = input a, 10 = input b, 11 = zero). It then starts the Montgomery multiplier, waits for its done pulse and steers the result into the Mbar or accumulator register. The block sits between the top-level SPI/register interface (start, exponent, done) and the multiplier/mux/register datapath.

## Interface
- WIDTH, 8, exponent and operand width in bits (≥ 2)
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin exponentiation; sampled only in IDLE
- exponent  input  WIDTH  exponent e; latched on accepted start
- mmm_done  input  1  multiplier done pulse; honored only in WAIT
- mmm_start  output  1  one-cycle multiplier start pulse
- mmm_square  output  1  multiplier uses operand A for both operands
- sel_a  output  2  operand-A mux select: a = accumulator A, b = message M
- sel_b  output  2  operand-B mux select: a = R² mod n, b = Mbar
- wr_mbar  output  1  load multiplier result into Mbar
- wr_acc  output  1  load multiplier result into accumulator A
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid in A

## Operation
- Ops in order, each one ISSUE cycle + WAIT:
  - PRE_M: sel_a=10, sel_b=01, square=0, dest Mbar (Mbar = M·R mod n).
  - PRE_A: sel_a=00, sel_b=01, square=0, dest A (A = R mod n).
  - Per bit i = WIDTH-1 down to 0:
    - SQR: sel_a=01, sel_b=11, square=1, dest A.
    - If e[i]=1, then MUL: sel_a=01, sel_b=10, square=0, dest A.
  - POST: sel_a=01, sel_b=00, square=0, dest A (leave Montgomery domain).
  - Then DONE, then IDLE.
- All WIDTH bits always processed; no leading-zero skip.
- Bit index counter: $clog2(WIDTH) bits, loaded WIDTH-1 on start, decremented after the SQR/MUL pair of each bit. Exit to POST after bit 0, without underflow or wrap.
- ISSUE: mmm_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - sel_a, sel_b and mmm_square are held constant from ISSUE through the mmm_done cycle.
  - On mmm_done, the matching wr_mbar/wr_acc is asserted combinationally in that same cycle. The FSM advances at that edge.
- Outside WAIT:
  - mmm_done is ignored.
  - wr_* stays 0.
- start while busy is ignored; the latched exponent does not change mid-operation.
- Exponent 0 → only PRE_M, PRE_A, WIDTH×SQR, POST. The final A = 1 from the datapath.

## Timing
- Reset (rst_n=0 at edge) from any state:
  - FSM → IDLE, counter → 0.
  - Next cycle outputs: mmm_start=0, mmm_square=0, sel_a=11, sel_b=11, wr_mbar=0, wr_acc=0, busy=0, done=0.
  - Any in-flight multiplier result is abandoned.
- IDLE outputs are the reset values.
- Start handshake and busy:
  - start sampled high at edge t0 → PRE_M ISSUE in cycle t0+1.
  - busy=1 from t0+1 through the DONE cycle inclusive.
- Per op: if mmm_done arrives k cycles after the mmm_start cycle (k ≥ 1), the op occupies k+1 cycles. The next ISSUE immediately follows the done cycle.
- Op count N = 3 + WIDTH + popcount(e).
  - done pulses in cycle t0 + N·(k+1) + 1.
  - IDLE follows; start is accepted again in the cycle after done.
- mmm_done coincident with mmm_start (ISSUE cycle) is ignored.

## Test plan
- Reset mid-SQR (rst_n low one cycle while in WAIT, with mmm_done pulsed in that same cycle) → no wr_acc; the following cycle shows all outputs at reset values, busy=0.
- WIDTH=8, e=0x0B, multiplier model k=3:
  - 14 mmm_start pulses.
  - Select trace PRE_M(10/01), PRE_A(00/01), then S,S,S,S,S,M,S,S,M,S,M, then POST(01/00).
  - done at cycle t0+57.
  - wr_mbar once, wr_acc 13×.
- e=0x00, k=1 → 11 ops, square=1 on 8 of them, no MUL, done at t0+23.
- e=0xFF, k=1 → 19 ops, strict SQR/MUL alternation, done at t0+39.
- Start pulsed during busy with a different exponent, plus spurious mmm_done during ISSUE and IDLE → trace identical to the undisturbed run; no extra wr_* pulses.
- End-to-end with a behavioral Montgomery model (n=0xC5, M=0x42, e=0x0B) → A equals M^e mod n; back-to-back second start accepted the cycle after done.

Source files
------------

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: sequences Montgomery left-to-right square-and-multiply over a WIDTH-bit exponent,
// driving the operand muxes, multiplier start and result write-back strobes.
module rsa_exp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] exponent,
    input  logic             mmm_done,
    output logic             mmm_start,
    output logic             mmm_square,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             wr_mbar,
    output logic             wr_acc,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] OP_PRE_M = 3'd0;
    localparam logic [2:0] OP_PRE_A = 3'd1;
    localparam logic [2:0] OP_SQR   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_POST  = 3'd4;

    logic [1:0]       state;
    logic [2:0]       op;
    logic [2:0]       next_op;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] exp_q;
    logic             active;
    logic             fin;
    logic             last_bit;
    logic             bit_done;

    assign active   = state == ST_ISSUE || state == ST_WAIT;
    // A result arriving in the reset cycle is abandoned, so it must not be written back.
    assign fin      = state == ST_WAIT && mmm_done && rst_n;
    assign last_bit = idx == '0;
    assign bit_done = op == OP_MUL || (op == OP_SQR && !exp_q[idx]);

    always_comb begin
        next_op = op == OP_PRE_M             ? OP_PRE_A :
                  op == OP_PRE_A             ? OP_SQR   :
                  op == OP_SQR && exp_q[idx] ? OP_MUL   :
                  bit_done && last_bit       ? OP_POST  :
                  bit_done                   ? OP_SQR   : op;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= OP_PRE_M;
            idx   <= '0;
            exp_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ISSUE;
                        op    <= OP_PRE_M;
                        idx   <= CW'(WIDTH - 1);
                        exp_q <= exponent;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mmm_done) begin
                        state <= op == OP_POST ? ST_DONE : ST_ISSUE;
                        op    <= next_op;
                        if (bit_done && !last_bit)
                            idx <= idx - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mmm_start  = state == ST_ISSUE;
    assign mmm_square = active && op == OP_SQR;
    assign sel_a      = !active          ? 2'b11 :
                        op == OP_PRE_M   ? 2'b10 :
                        op == OP_PRE_A   ? 2'b00 : 2'b01;
    assign sel_b      = !active                          ? 2'b11 :
                        op == OP_PRE_M || op == OP_PRE_A ? 2'b01 :
                        op == OP_SQR                     ? 2'b11 :
                        op == OP_MUL                     ? 2'b10 : 2'b00;
    assign wr_mbar    = fin && op == OP_PRE_M;
    assign wr_acc     = fin && op != OP_PRE_M;
    assign busy       = state != ST_IDLE;
    assign done       = state == ST_DONE;
endmodule
